// File: rtl/alu_stage_pkg.sv
// alu_stage_pkg
// Shared types and constants for the execute/write-back stage of the 8-bit core.
//   opcode_e    : 4-bit instruction opcodes (values A-F are illegal)
//   state_e     : IDLE -> READ -> EXEC -> (WB) -> IDLE sequencing states
//   flags_t     : packed {n, c, z} condition flags for the branch unit
//   *_MSB/_LSB  : bit positions of the rd/rs1/rs2/imm8 fields in the 16-bit word
//   is_illegal_op / writes_back : opcode classification helpers
package alu_stage_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_AND = 4'h3,
    OP_OR  = 4'h4,
    OP_XOR = 4'h5,
    OP_SHL = 4'h6,
    OP_SHR = 4'h7,
    OP_LDI = 4'h8,
    OP_CMP = 4'h9
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  typedef struct packed {
    logic n;
    logic c;
    logic z;
  } flags_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes above CMP have no defined behaviour and are executed as NOP.
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op > 4'h9);
  endfunction

  // Only these opcodes spend a WB cycle; NOP, CMP and illegal ops return
  // straight to IDLE after EXEC.
  function automatic logic writes_back(input opcode_e op);
    logic wb;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_SHL, OP_SHR, OP_LDI: wb = 1'b1;
      default:                        wb = 1'b0;
    endcase
    return wb;
  endfunction

endpackage

// File: rtl/alu_stage_if.sv
// alu_stage_if
// Bundles the instruction handshake, the register-file ports and the status
// outputs of alu_stage.
//   slave  : the stage side (takes instructions, drives the register file)
//   master : the environment side (issues instructions, models the register file)
// Signals:
//   instr_valid/instr/instr_ready : instruction handshake
//   rf_sel_o1/rf_sel_o2, rf_o1/rf_o2 : two combinational read ports
//   rf_we/rf_sel_in/rf_in : write port
//   flags {N,C,Z}, illegal pulse, busy
interface alu_stage_if;

  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  rf_sel_o1;
  logic [3:0]  rf_sel_o2;
  logic [7:0]  rf_o1;
  logic [7:0]  rf_o2;
  logic        rf_we;
  logic [3:0]  rf_sel_in;
  logic [7:0]  rf_in;
  logic [2:0]  flags;
  logic        illegal;
  logic        busy;

  modport slave (
    input  instr_valid, instr, rf_o1, rf_o2,
    output instr_ready, rf_sel_o1, rf_sel_o2, rf_we, rf_sel_in, rf_in,
           flags, illegal, busy
  );

  modport master (
    output instr_valid, instr, rf_o1, rf_o2,
    input  instr_ready, rf_sel_o1, rf_sel_o2, rf_we, rf_sel_in, rf_in,
           flags, illegal, busy
  );

endinterface

// File: rtl/alu_stage_alu8.sv
// alu8
// Purely combinational 8-bit ALU used in the EXEC cycle of alu_stage.
//   op          : opcode of the latched instruction
//   a, b        : operands captured from the register file
//   imm8        : immediate field, used by LDI
//   result      : 8-bit result
//   c           : carry/borrow/shifted-out bit
//   flag_update : high when this opcode updates N/C/Z
module alu8
  import alu_stage_pkg::*;
(
  input  opcode_e    op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm8,
  output logic [7:0] result,
  output logic       c,
  output logic       flag_update
);

  logic [8:0] ext;

  // Arithmetic is done in 9 bits so the carry falls out as bit 8. For shifts,
  // the extra bit sits on the side the data leaves, so it ends up holding the
  // last bit shifted out (and stays 0 for a zero shift amount).
  always_comb begin
    ext         = 9'd0;
    result      = 8'd0;
    c           = 1'b0;
    flag_update = 1'b0;
    case (op)
      OP_ADD: begin
        ext         = {1'b0, a} + {1'b0, b};
        result      = ext[7:0];
        c           = ext[8];
        flag_update = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        ext         = {1'b0, a} - {1'b0, b};
        result      = ext[7:0];
        c           = ext[8];
        flag_update = 1'b1;
      end
      OP_AND: begin
        result      = a & b;
        flag_update = 1'b1;
      end
      OP_OR: begin
        result      = a | b;
        flag_update = 1'b1;
      end
      OP_XOR: begin
        result      = a ^ b;
        flag_update = 1'b1;
      end
      OP_SHL: begin
        ext         = {1'b0, a} << b[2:0];
        result      = ext[7:0];
        c           = ext[8];
        flag_update = 1'b1;
      end
      OP_SHR: begin
        ext         = {a, 1'b0} >> b[2:0];
        result      = ext[8:1];
        c           = ext[0];
        flag_update = 1'b1;
      end
      OP_LDI: begin
        result = imm8;
      end
      default: begin
        result = 8'd0;
      end
    endcase
  end

endmodule

// File: rtl/alu_stage.sv
// alu_stage
// Multi-cycle execute/write-back stage in front of the 16x8 register file.
// One instruction is accepted per handshake in IDLE, its sources are read in
// READ, the ALU result is latched in EXEC, and it is written back in WB.
// Ports:
//   clk : rising-edge clock shared with the register file
//   rst : synchronous active-high reset, wins in every state
//   bus : alu_stage_if.slave (handshake, register-file ports, flags, status)
module alu_stage
  import alu_stage_pkg::*;
(
  input logic        clk,
  input logic        rst,
  alu_stage_if.slave bus
);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [7:0]  result_q, result_d;
  flags_t      flags_q, flags_d;
  logic        illegal_q, illegal_d;

  opcode_e     op;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [7:0]  imm8;

  logic [7:0]  alu_result;
  logic        alu_c;
  logic        alu_flag_update;

  assign op   = opcode_e'(instr_q[OPC_MSB:OPC_LSB]);
  assign rd   = instr_q[RD_MSB:RD_LSB];
  assign rs1  = instr_q[RS1_MSB:RS1_LSB];
  assign rs2  = instr_q[RS2_MSB:RS2_LSB];
  assign imm8 = instr_q[IMM_MSB:IMM_LSB];

  alu8 u_alu8 (
    .op          (op),
    .a           (a_q),
    .b           (b_q),
    .imm8        (imm8),
    .result      (alu_result),
    .c           (alu_c),
    .flag_update (alu_flag_update)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ops with nothing to write leave straight from EXEC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.instr_valid) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = writes_back(op) ? ST_WB : ST_IDLE;
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: the instruction is captured only at the handshake,
  // operands in READ, result/flags/illegal in EXEC. LDI and NOP/illegal keep
  // the flags because the ALU reports no flag update for them.
  always_comb begin
    instr_d   = instr_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    flags_d   = flags_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) instr_d = bus.instr;
      end
      ST_READ: begin
        a_d = bus.rf_o1;
        b_d = bus.rf_o2;
      end
      ST_EXEC: begin
        result_d  = alu_result;
        illegal_d = is_illegal_op(instr_q[OPC_MSB:OPC_LSB]);
        if (alu_flag_update) begin
          flags_d.n = alu_result[7];
          flags_d.c = alu_c;
          flags_d.z = (alu_result == 8'd0);
        end
      end
      default: begin
        instr_d = instr_q;
      end
    endcase
  end

  // Datapath registers, all cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q   <= 16'd0;
      a_q       <= 8'd0;
      b_q       <= 8'd0;
      result_q  <= 8'd0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      instr_q   <= instr_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs decoded from registered state. The write enable is also gated by
  // rst so a reset arriving during WB drops the write in that same cycle;
  // r0 is never written.
  always_comb begin
    bus.instr_ready = (state_q == ST_IDLE);
    bus.busy        = (state_q != ST_IDLE);
    bus.rf_sel_o1   = rs1;
    bus.rf_sel_o2   = rs2;
    bus.rf_sel_in   = rd;
    bus.rf_in       = result_q;
    bus.rf_we       = (state_q == ST_WB) && (rd != 4'd0) && !rst;
    bus.flags       = flags_q;
    bus.illegal     = illegal_q;
  end

endmodule

// File: tb/tb_alu_stage.sv
// tb_alu_stage
// Directed-vector bench for alu_stage. It models the 16x8 register file the
// stage drives, keeps a transaction-level reference model that turns each
// accepted instruction into a per-cycle timeline of expected outputs, and
// checks the DUT against that timeline every cycle, plus literal expectations
// for the headline vectors.
module tb_alu_stage;

  logic clk;
  logic rst;

  alu_stage_if bus ();

  alu_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Register file seen by the stage: combinational reads, write at the edge.
  logic [7:0] regs [16];
  bit         regs_init;
  int         we_count;
  int         illegal_count;
  logic [3:0] last_sel;
  logic [7:0] last_data;

  assign bus.rf_o1 = regs[bus.rf_sel_o1];
  assign bus.rf_o2 = regs[bus.rf_sel_o2];

  always @(posedge clk) begin
    if (!regs_init) begin
      for (int i = 0; i < 16; i++) regs[i] <= 8'd0;
      regs_init     <= 1'b1;
      we_count      <= 0;
      illegal_count <= 0;
      last_sel      <= 4'd0;
      last_data     <= 8'd0;
    end else begin
      if (bus.rf_we) begin
        regs[bus.rf_sel_in] <= bus.rf_in;
        last_sel            <= bus.rf_sel_in;
        last_data           <= bus.rf_in;
        we_count            <= we_count + 1;
      end
      if (bus.illegal) illegal_count <= illegal_count + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic flagTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s timed out at %0t", name, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit         ready;
    bit         busy;
    bit         we;
    bit         rd_phase;
    logic [3:0] sel_in;
    logic [7:0] data;
    logic [2:0] flags;
    bit         illegal;
    logic [3:0] s1;
    logic [3:0] s2;
  } exp_t;

  exp_t       q[$];
  exp_t       cur;
  logic [7:0] m_regs [16];
  logic [2:0] m_flags;
  logic [3:0] m_rd;
  bit         model_live;

  function automatic exp_t idleExp();
    exp_t e;
    e.ready    = 1'b1;
    e.busy     = 1'b0;
    e.we       = 1'b0;
    e.rd_phase = 1'b0;
    e.sel_in   = m_rd;
    e.data     = 8'd0;
    e.flags    = m_flags;
    e.illegal  = 1'b0;
    e.s1       = 4'd0;
    e.s2       = 4'd0;
    return e;
  endfunction

  function automatic void modelOp(input logic [3:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [7:0] imm,
                                  output logic [7:0] res, output logic cy,
                                  output logic upd, output logic wr);
    int ai, bi, amt, r;
    ai  = int'(a);
    bi  = int'(b);
    amt = bi % 8;
    r   = 0;
    cy  = 1'b0;
    upd = 1'b1;
    wr  = 1'b1;
    case (op)
      4'd1: begin r = ai + bi; cy = (r > 255); end
      4'd2: begin r = ai - bi; cy = (ai < bi); end
      4'd9: begin r = ai - bi; cy = (ai < bi); wr = 1'b0; end
      4'd3: r = ai & bi;
      4'd4: r = ai | bi;
      4'd5: r = ai ^ bi;
      4'd6: begin r = ai << amt; cy = (amt != 0) && (((ai >> (8 - amt)) & 1) == 1); end
      4'd7: begin r = ai >> amt; cy = (amt != 0) && (((ai >> (amt - 1)) & 1) == 1); end
      4'd8: begin r = int'(imm); upd = 1'b0; end
      default: begin upd = 1'b0; wr = 1'b0; end
    endcase
    res = 8'(r & 255);
  endfunction

  task automatic schedule(input logic [15:0] w);
    exp_t       e;
    logic [7:0] res;
    logic       cy, upd, wr;
    modelOp(w[15:12], m_regs[w[7:4]], m_regs[w[3:0]], w[7:0], res, cy, upd, wr);
    m_rd       = w[11:8];
    e          = idleExp();
    e.ready    = 1'b0;
    e.busy     = 1'b1;
    e.rd_phase = 1'b1;
    e.s1       = w[7:4];
    e.s2       = w[3:0];
    q.push_back(e);
    e.rd_phase = 1'b0;
    q.push_back(e);
    if (upd) m_flags = {res[7], cy, (res == 8'd0)};
    if (wr) begin
      e.we    = (w[11:8] != 4'd0);
      e.data  = res;
      e.flags = m_flags;
      q.push_back(e);
    end else if (w[15:12] >= 4'd10) begin
      e         = idleExp();
      e.illegal = 1'b1;
      q.push_back(e);
    end
  endtask

  initial begin
    exp_t prev;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'd0;
    m_flags    = 3'd0;
    m_rd       = 4'd0;
    model_live = 1'b0;
    cur        = idleExp();
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        m_flags    = 3'd0;
        m_rd       = 4'd0;
        model_live = 1'b1;
        cur        = idleExp();
      end else if (model_live) begin
        prev = cur;
        if (prev.we) m_regs[prev.sel_in] = prev.data;
        if (prev.ready && bus.instr_valid) schedule(bus.instr);
        if (q.size() > 0) cur = q.pop_front();
        else cur = idleExp();
      end
    end
  end

  // Per-cycle compare against the model timeline.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        if (model_live) checkOutput("rf_we_in_rst", 16'(bus.rf_we), 16'd0);
      end else if (model_live) begin
        checkOutput("instr_ready", 16'(bus.instr_ready), 16'(cur.ready));
        checkOutput("busy", 16'(bus.busy), 16'(cur.busy));
        checkOutput("rf_we", 16'(bus.rf_we), 16'(cur.we));
        checkOutput("rf_sel_in", 16'(bus.rf_sel_in), 16'(cur.sel_in));
        checkOutput("flags", 16'(bus.flags), 16'(cur.flags));
        checkOutput("illegal", 16'(bus.illegal), 16'(cur.illegal));
        if (cur.we) checkOutput("rf_in", 16'(bus.rf_in), 16'(cur.data));
        if (cur.rd_phase) begin
          checkOutput("rf_sel_o1", 16'(bus.rf_sel_o1), 16'(cur.s1));
          checkOutput("rf_sel_o2", 16'(bus.rf_sel_o2), 16'(cur.s2));
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic applyStimulus(input logic [15:0] word, output int cycles);
    int guard;
    guard = 0;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) flagTimeout("ready_wait");
    bus.instr       = word;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    cycles = 0;
    @(negedge clk);
    while (bus.instr_ready !== 1'b1 && cycles < 20) begin
      cycles++;
      @(negedge clk);
    end
    if (cycles >= 20) flagTimeout("done_wait");
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc;
    int wc0;
    int ic0;
    int hs;
    int guard;
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_ready", 16'(bus.instr_ready), 16'd1);
    checkOutput("rst_busy", 16'(bus.busy), 16'd0);
    checkOutput("rst_flags", 16'(bus.flags), 16'd0);
    checkOutput("rst_we", 16'(bus.rf_we), 16'd0);
    checkOutput("rst_sel_in", 16'(bus.rf_sel_in), 16'd0);
    checkOutput("rst_rf_in", 16'(bus.rf_in), 16'd0);

    applyStimulus(16'h817F, cyc);
    applyStimulus(16'h8201, cyc);
    checkOutput("ldi_r2", 16'(regs[2]), 16'h01);

    applyStimulus(16'h1312, cyc);
    checkOutput("add_sel", 16'(last_sel), 16'd3);
    checkOutput("add_data", 16'(last_data), 16'h80);
    checkOutput("add_flags", 16'(bus.flags), 16'b100);
    checkOutput("add_cycles", 16'(cyc), 16'd3);

    applyStimulus(16'h2421, cyc);
    checkOutput("sub_data", 16'(last_data), 16'h82);
    checkOutput("sub_flags", 16'(bus.flags), 16'b110);

    wc0 = we_count;
    applyStimulus(16'h9011, cyc);
    checkOutput("cmp_no_write", 16'(we_count - wc0), 16'd0);
    checkOutput("cmp_flags", 16'(bus.flags), 16'b001);
    checkOutput("cmp_cycles", 16'(cyc), 16'd2);

    applyStimulus(16'h6512, cyc);
    checkOutput("shl_data", 16'(last_data), 16'hFE);
    checkOutput("shl_flags", 16'(bus.flags), 16'b100);

    applyStimulus(16'h8708, cyc);
    applyStimulus(16'h7817, cyc);
    checkOutput("shr0_data", 16'(last_data), 16'h7F);
    checkOutput("shr0_flags", 16'(bus.flags), 16'b000);

    applyStimulus(16'h7912, cyc);
    checkOutput("shr1_data", 16'(last_data), 16'h3F);
    checkOutput("shr1_flags", 16'(bus.flags), 16'b010);

    applyStimulus(16'h3B14, cyc);
    checkOutput("and_data", 16'(last_data), 16'h02);
    applyStimulus(16'h4C24, cyc);
    checkOutput("or_data", 16'(last_data), 16'h83);
    applyStimulus(16'h5D11, cyc);
    checkOutput("xor_flags", 16'(bus.flags), 16'b001);
    applyStimulus(16'h1E44, cyc);
    checkOutput("addc_data", 16'(last_data), 16'h04);
    checkOutput("addc_flags", 16'(bus.flags), 16'b010);

    wc0 = we_count;
    applyStimulus(16'h8055, cyc);
    checkOutput("ldi_r0_no_write", 16'(we_count - wc0), 16'd0);
    checkOutput("ldi_r0_cycles", 16'(cyc), 16'd3);
    checkOutput("ldi_r0_reg", 16'(regs[0]), 16'd0);

    wc0 = we_count;
    ic0 = illegal_count;
    applyStimulus(16'hC123, cyc);
    @(negedge clk);
    checkOutput("illegal_pulses", 16'(illegal_count - ic0), 16'd1);
    checkOutput("illegal_no_write", 16'(we_count - wc0), 16'd0);
    checkOutput("illegal_cycles", 16'(cyc), 16'd2);
    checkOutput("illegal_flags", 16'(bus.flags), 16'b010);

    // Stream of ADD r10,r1,r2 with instr_valid held high.
    bus.instr       = 16'h1A12;
    bus.instr_valid = 1'b1;
    hs = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.instr_ready && bus.instr_valid) hs++;
      checkOutput("ready_while_busy", 16'(bus.instr_ready & bus.busy), 16'd0);
      @(negedge clk);
    end
    bus.instr_valid = 1'b0;
    checkOutput("stream_handshakes", 16'(hs), 16'd3);
    guard = 0;
    while (bus.instr_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) flagTimeout("stream_drain");
    checkOutput("stream_r10", 16'(regs[10]), 16'h80);

    // Reset during WB of ADD r6,r1,r2.
    bus.instr       = 16'h1612;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("wb_rst_we", 16'(bus.rf_we), 16'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_busy", 16'(bus.busy), 16'd0);
    checkOutput("post_rst_ready", 16'(bus.instr_ready), 16'd1);
    checkOutput("post_rst_flags", 16'(bus.flags), 16'd0);
    checkOutput("post_rst_r6", 16'(regs[6]), 16'd0);

    applyStimulus(16'h1F12, cyc);
    checkOutput("after_rst_add", 16'(last_data), 16'h80);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_stage.md
# alu_stage

Multi-cycle execute/write-back stage of the 8-bit core, directly upstream of the 16×8 register file. Accepts one 16-bit instruction per handshake, drives the register file's two read selects, computes an 8-bit ALU result, and writes it back through the register file's write port. Maintains Z/C/N flags for the branch unit.

## Interface
Parameters: none (data width fixed at 8, register count fixed at 16).
- clk  in  1  rising-edge clock, shared with the register file
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction word present
- instr  in  16  [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2; [7:0] imm8 for LDI
- instr_ready  out  1  stage can accept; high only in IDLE
- rf_sel_o1  out  4  register file read select 1
- rf_sel_o2  out  4  register file read select 2
- rf_o1  in  8  register file read data 1 (combinational from rf_sel_o1)
- rf_o2  in  8  register file read data 2 (combinational from rf_sel_o2)
- rf_we  out  1  register file write enable, one-cycle pulse
- rf_sel_in  out  4  register file write select
- rf_in  out  8  register file write data
- flags  out  3  {N, C, Z}
- illegal  out  1  one-cycle pulse: opcode A–F accepted
- busy  out  1  not in IDLE

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 LDI (rd ← imm8), 9 CMP (SUB, flags only, no write), A–F illegal (handled as NOP plus `illegal` pulse).
- States: IDLE → READ → EXEC → WB → IDLE. NOP, CMP, and illegal skip WB (EXEC → IDLE).
- IDLE: instr_ready=1. Handshake completes when instr_valid && instr_ready; instr is latched into the internal instruction register, then go to READ.
- READ: rf_sel_o1=rs1 and rf_sel_o2=rs2 from the latched instruction; capture rf_o1/rf_o2 into operand registers A/B.
- EXEC: compute result from A and B in 9-bit arithmetic and latch it into the result register.
  - ADD: C = bit 8.
  - SUB/CMP: C = borrow (A < B unsigned).
  - SHL/SHR: shift amount = B[2:0]; C = last bit shifted out; C = 0 when amount is 0.
  - AND/OR/XOR: C = 0.
  - LDI: result = imm8; flags are unchanged.
  - All other flag-updating ops: Z = (result == 0), N = result[7].
- WB: rf_sel_in=rd, rf_in=result, rf_we=1 for exactly this cycle. rf_we is suppressed when rd==0 (r0 is not writable); the cycle is still spent.
- Outside WB: rf_we=0. rf_sel_in holds the latched rd, so the register file's o0 port shows the destination register.
- Reset: takes priority in any state, including mid-instruction.
  - State goes to IDLE; any in-flight write is dropped.
  - rf_we=0, flags=0, illegal=0, busy=0, instr_ready=1.
  - All select outputs and rf_in are 0; the instruction, operand, and result registers are cleared.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from instr_valid to any output.
- Handshake at edge 0 → READ in cycle 1, EXEC in cycle 2, WB (rf_we) in cycle 3, instr_ready high again in cycle 4.
- Throughput: one instruction per 4 cycles; NOP/CMP/illegal take 3 cycles.
- Flags change at the edge that ends EXEC.
- `illegal` is high during the cycle following EXEC.
- Back-to-back dependency (rd of instruction N used as a source by instruction N+1) needs no forwarding: N's write lands at the end of cycle 3, and N+1's READ is no earlier than cycle 5.
- instr_valid held high during busy has no effect; instr is sampled only at the handshake.

## Structure
- Package `alu_stage_pkg` holds:
  - the opcode enum (4-bit) and state enum;
  - a flags struct {n, c, z};
  - field-slice localparams for rd/rs1/rs2/imm8.
- Sub-module `alu8`: purely combinational. Inputs: op, a, b, imm8. Outputs: result[7:0], c, and flag_update. It is instantiated once in the EXEC datapath.

## Test plan
- Reset, then preload r1=0x7F and r2=0x01 via LDI. ADD r3,r1,r2 → rf_we in cycle 3 with rf_sel_in=3, rf_in=0x80; flags N=1, C=0, Z=0.
- SUB r4,r2,r1 (0x01−0x7F) → rf_in=0x82, C=1, N=1. CMP r0,r1,r1 → no rf_we, Z=1, C=0.
- SHL r5,r1,r2 with r2=0x01 → 0xFE, C=0. SHR with B=0x08 (amount 0) → unchanged value, C=0.
- LDI r0,0x55 → rf_we stays 0 throughout. Opcode 0xC → illegal pulses once, no write, 3-cycle occupancy.
- Hold instr_valid high for 10 cycles with a stream of ADDs → exactly one handshake per 4 cycles; instr_ready is never high while busy.
- Assert rst during WB of ADD r6 → rf_we is 0 in that cycle, state is IDLE next cycle, flags=0, and r6 is unchanged.
